// File: rtl/dm_mm2s_responder_if.sv
// Stream bundle for the datamover MM2S responder: command in, read data and status out.
interface dm_mm2s_responder_if;
  logic        s_axis_cmd_tvalid;
  logic        s_axis_cmd_tready;
  logic [71:0] s_axis_cmd_tdata;

  logic        m_axis_data_tvalid;
  logic        m_axis_data_tready;
  logic [63:0] m_axis_data_tdata;
  logic [7:0]  m_axis_data_tkeep;
  logic        m_axis_data_tlast;

  logic        m_axis_sts_tvalid;
  logic        m_axis_sts_tready;
  logic [7:0]  m_axis_sts_tdata;
  logic [0:0]  m_axis_sts_tkeep;
  logic        m_axis_sts_tlast;

  // Command issuer / data and status consumer
  modport master (
    output s_axis_cmd_tvalid, s_axis_cmd_tdata, m_axis_data_tready, m_axis_sts_tready,
    input  s_axis_cmd_tready,
    input  m_axis_data_tvalid, m_axis_data_tdata, m_axis_data_tkeep, m_axis_data_tlast,
    input  m_axis_sts_tvalid, m_axis_sts_tdata, m_axis_sts_tkeep, m_axis_sts_tlast
  );

  // Responder side
  modport slave (
    input  s_axis_cmd_tvalid, s_axis_cmd_tdata, m_axis_data_tready, m_axis_sts_tready,
    output s_axis_cmd_tready,
    output m_axis_data_tvalid, m_axis_data_tdata, m_axis_data_tkeep, m_axis_data_tlast,
    output m_axis_sts_tvalid, m_axis_sts_tdata, m_axis_sts_tkeep, m_axis_sts_tlast
  );
endinterface

// File: rtl/dm_mm2s_responder.sv
// Datamover MM2S responder model: accepts one read command at a time, streams
// address-pattern data beats after a fixed latency, then returns one status byte.
module dm_mm2s_responder #(
  parameter int unsigned LAT_CYCLES = 2,
  parameter logic [31:0] BASE_LIMIT = 32'h1000_0000
) (
  input logic                  clk,
  input logic                  rst,
  dm_mm2s_responder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DATA, STS} state_t;

  state_t      state_q, state_d;
  logic        armed_q;
  logic [7:0]  wait_cnt_q;
  logic [19:0] beats_left_q;
  logic [31:0] addr_q;
  logic [2:0]  rem_q;
  logic [3:0]  tag_q;
  logic        eof_q;
  logic [3:0]  sts_code_q;

  logic [22:0] cmd_btt;
  logic        cmd_eof;
  logic [31:0] cmd_saddr;
  logic [3:0]  cmd_tag;
  logic [32:0] cmd_end;
  logic        cmd_interr;
  logic        cmd_decerr;
  logic [19:0] cmd_beats_m1;
  logic [10:0] cmd_unused;

  logic        cmd_ready;
  logic        cmd_accept;
  logic        data_valid;
  logic        data_last;
  logic        data_hs;
  logic        sts_valid;
  logic        sts_hs;

  assign cmd_btt      = bus.s_axis_cmd_tdata[22:0];
  assign cmd_eof      = bus.s_axis_cmd_tdata[30];
  assign cmd_saddr    = bus.s_axis_cmd_tdata[63:32];
  assign cmd_tag      = bus.s_axis_cmd_tdata[67:64];
  // TYPE and reserved bits carry no meaning here; transfers are always INCR
  assign cmd_unused   = {bus.s_axis_cmd_tdata[71:68], bus.s_axis_cmd_tdata[29:23]};
  assign cmd_end      = {1'b0, cmd_saddr} + {10'd0, cmd_btt};
  assign cmd_interr   = (cmd_btt == 23'd0);
  assign cmd_decerr   = (cmd_saddr >= BASE_LIMIT) || cmd_end[32];
  // Remaining-beat counter holds N-1 so a full 2^20-beat transfer fits in 20 bits
  assign cmd_beats_m1 = 20'((cmd_btt - 23'd1) >> 3);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake decode
  always_comb begin
    state_d    = state_q;
    cmd_ready  = armed_q && (state_q == IDLE);
    cmd_accept = cmd_ready && bus.s_axis_cmd_tvalid;
    data_valid = (state_q == DATA);
    sts_valid  = (state_q == STS);
    data_last  = data_valid && (beats_left_q == 20'd0);
    data_hs    = data_valid && bus.m_axis_data_tready;
    sts_hs     = sts_valid && bus.m_axis_sts_tready;
    case (state_q)
      IDLE: if (cmd_accept) begin
        if (cmd_interr || cmd_decerr) state_d = STS;
        else if (LAT_CYCLES == 0)     state_d = DATA;
        else                          state_d = WAIT;
      end
      WAIT: if (wait_cnt_q <= 8'd1) state_d = DATA;
      DATA: if (data_hs && data_last) state_d = STS;
      STS:  if (sts_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture, latency countdown and beat advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q      <= 1'b0;
      wait_cnt_q   <= '0;
      beats_left_q <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      tag_q        <= '0;
      eof_q        <= 1'b0;
      sts_code_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      if (cmd_accept) begin
        addr_q       <= cmd_saddr;
        beats_left_q <= cmd_beats_m1;
        rem_q        <= cmd_btt[2:0];
        tag_q        <= cmd_tag;
        eof_q        <= cmd_eof;
        wait_cnt_q   <= 8'(LAT_CYCLES);
        if (cmd_interr)      sts_code_q <= 4'b0001;
        else if (cmd_decerr) sts_code_q <= 4'b0010;
        else                 sts_code_q <= 4'b1000;
      end
      if (state_q == WAIT && wait_cnt_q != 8'd0) wait_cnt_q <= wait_cnt_q - 8'd1;
      if (data_hs) begin
        addr_q <= addr_q + 32'd8;
        if (!data_last) beats_left_q <= beats_left_q - 20'd1;
      end
    end
  end

  assign bus.s_axis_cmd_tready  = cmd_ready;

  assign bus.m_axis_data_tvalid = data_valid;
  assign bus.m_axis_data_tdata  = data_valid ? {addr_q + 32'd4, addr_q} : '0;
  assign bus.m_axis_data_tkeep  = !data_valid ? '0 :
                                  (data_last && rem_q != 3'd0) ? (8'hFF >> (4'd8 - {1'b0, rem_q})) :
                                  8'hFF;
  assign bus.m_axis_data_tlast  = data_last && eof_q;

  assign bus.m_axis_sts_tvalid  = sts_valid;
  assign bus.m_axis_sts_tdata   = sts_valid ? {sts_code_q, tag_q} : '0;
  assign bus.m_axis_sts_tkeep   = sts_valid;
  assign bus.m_axis_sts_tlast   = sts_valid;

endmodule

// File: tb/tb_dm_mm2s_responder.sv
// Directed bench for dm_mm2s_responder: a vector table of commands with
// hand-computed beat counts, last-beat keeps and status bytes, plus
// hand-written busy back-pressure and mid-transfer reset sequences.
module tb_dm_mm2s_responder;

  typedef struct {
    bit          sel;        // 0: LAT=2 default instance, 1: LAT=0 / full-range instance
    logic [22:0] btt;
    logic [31:0] saddr;
    logic [3:0]  tag;
    bit          eof;
    bit          stall;
    int unsigned beats;
    logic [7:0]  last_keep;
    logic [7:0]  sts;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned total = 0;
  int unsigned bad = 0;

  bit          sel = 1'b0;
  logic        cmd_tvalid = 1'b0;
  logic [71:0] cmd_tdata = '0;
  logic        data_tready = 1'b0;
  logic        sts_tready = 1'b0;

  dm_mm2s_responder_if a ();
  dm_mm2s_responder_if b ();

  dm_mm2s_responder dut_a (.clk(clk), .rst(rst), .bus(a));
  dm_mm2s_responder #(.LAT_CYCLES(0), .BASE_LIMIT(32'hFFFF_FFFF)) dut_b (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;

  assign a.s_axis_cmd_tvalid  = cmd_tvalid & ~sel;
  assign b.s_axis_cmd_tvalid  = cmd_tvalid & sel;
  assign a.s_axis_cmd_tdata   = cmd_tdata;
  assign b.s_axis_cmd_tdata   = cmd_tdata;
  assign a.m_axis_data_tready = data_tready & ~sel;
  assign b.m_axis_data_tready = data_tready & sel;
  assign a.m_axis_sts_tready  = sts_tready & ~sel;
  assign b.m_axis_sts_tready  = sts_tready & sel;

  logic        rdy, d_tvalid, d_tlast, s_tvalid, s_tlast;
  logic [63:0] d_tdata;
  logic [7:0]  d_tkeep, s_tdata;
  logic [0:0]  s_tkeep;
  assign rdy      = sel ? b.s_axis_cmd_tready  : a.s_axis_cmd_tready;
  assign d_tvalid = sel ? b.m_axis_data_tvalid : a.m_axis_data_tvalid;
  assign d_tdata  = sel ? b.m_axis_data_tdata  : a.m_axis_data_tdata;
  assign d_tkeep  = sel ? b.m_axis_data_tkeep  : a.m_axis_data_tkeep;
  assign d_tlast  = sel ? b.m_axis_data_tlast  : a.m_axis_data_tlast;
  assign s_tvalid = sel ? b.m_axis_sts_tvalid  : a.m_axis_sts_tvalid;
  assign s_tdata  = sel ? b.m_axis_sts_tdata   : a.m_axis_sts_tdata;
  assign s_tkeep  = sel ? b.m_axis_sts_tkeep   : a.m_axis_sts_tkeep;
  assign s_tlast  = sel ? b.m_axis_sts_tlast   : a.m_axis_sts_tlast;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // All outputs of the selected instance must be zero (reset state)
  task automatic check_zero(input string tag);
    check({tag, "_cmd_tready"}, {63'd0, rdy}, 64'd0);
    check({tag, "_d_tvalid"}, {63'd0, d_tvalid}, 64'd0);
    check({tag, "_d_tdata"}, d_tdata, 64'd0);
    check({tag, "_d_tkeep"}, {56'd0, d_tkeep}, 64'd0);
    check({tag, "_d_tlast"}, {63'd0, d_tlast}, 64'd0);
    check({tag, "_s_tvalid"}, {63'd0, s_tvalid}, 64'd0);
    check({tag, "_s_tdata"}, {56'd0, s_tdata}, 64'd0);
    check({tag, "_s_tkeep"}, {63'd0, s_tkeep}, 64'd0);
    check({tag, "_s_tlast"}, {63'd0, s_tlast}, 64'd0);
  endtask

  // Present a command and wait for its accept edge; returns at the following negedge
  task automatic issue_cmd(input vec_t v);
    int unsigned n = 0;
    sel = v.sel;
    cmd_tdata = '0;
    cmd_tdata[22:0]  = v.btt;
    cmd_tdata[23]    = v.tag[0];
    cmd_tdata[30]    = v.eof;
    cmd_tdata[63:32] = v.saddr;
    cmd_tdata[67:64] = v.tag;
    cmd_tvalid = 1'b1;
    #1;
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_tvalid = 1'b0;
  endtask

  // Consume beats and status of an accepted command; starts one cycle after accept
  task automatic collect(input vec_t v);
    int unsigned k = 0, cyc = 0, first_d = 0, first_s = 0, busy_rdy = 0, lat;
    bit done = 1'b0;
    logic [31:0] ea;
    logic [7:0]  ekeep;
    logic        elast;
    lat = v.sel ? 0 : 2;
    while (!done && cyc < 300) begin
      cyc++;
      if (rdy) busy_rdy++;
      data_tready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      sts_tready  = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      check("valid_exclusive", {63'd0, d_tvalid & s_tvalid}, 64'd0);
      if (d_tvalid) begin
        if (first_d == 0) first_d = cyc;
        ea    = v.saddr + 32'(k) * 32'd8;
        ekeep = (k == v.beats - 1) ? v.last_keep : 8'hFF;
        elast = (k == v.beats - 1) && v.eof;
        check("beat_tdata", d_tdata, {ea + 32'd4, ea});
        check("beat_tkeep", {56'd0, d_tkeep}, {56'd0, ekeep});
        check("beat_tlast", {63'd0, d_tlast}, {63'd0, elast});
        if (data_tready) k++;
      end else if (s_tvalid) begin
        if (first_s == 0) first_s = cyc;
        check("sts_tdata", {56'd0, s_tdata}, {56'd0, v.sts});
        check("sts_tkeep_tlast", {62'd0, s_tkeep, s_tlast}, 64'd3);
        if (sts_tready) done = 1'b1;
      end
      @(negedge clk);
    end
    data_tready = 1'b0;
    sts_tready  = 1'b0;
    check("sts_handshake_seen", {63'd0, done}, 64'd1);
    check("beat_count", 64'(k), 64'(v.beats));
    if (v.beats > 0) check("first_beat_latency", 64'(first_d), 64'(lat + 1));
    else             check("sts_latency", 64'(first_s), 64'd1);
    check("cmd_tready_while_busy", 64'(busy_rdy), 64'd0);
    #1;
    check("cmd_tready_after_sts", {63'd0, rdy}, 64'd1);
  endtask

  vec_t vecs [12];
  vec_t c1, c2, c6;

  initial begin
    //          sel  btt     saddr          tag   eof stall beats keep   sts
    vecs[0]  = '{0, 23'd20, 32'h0000_0100, 4'h5, 1, 0, 3, 8'h0F, 8'h85};
    vecs[1]  = '{0, 23'd0,  32'h0000_0200, 4'h3, 1, 0, 0, 8'hFF, 8'h13};
    vecs[2]  = '{0, 23'd8,  32'h1000_0000, 4'h1, 1, 0, 0, 8'hFF, 8'h21};
    vecs[3]  = '{0, 23'd16, 32'h0000_2000, 4'h7, 1, 1, 2, 8'hFF, 8'h87};
    vecs[4]  = '{0, 23'd16, 32'h0000_3000, 4'h2, 0, 1, 2, 8'hFF, 8'h82};
    vecs[5]  = '{0, 23'd1,  32'h0FFF_FFFF, 4'h4, 1, 0, 1, 8'h01, 8'h84};
    vecs[6]  = '{0, 23'd9,  32'h0000_0040, 4'h6, 1, 1, 2, 8'h01, 8'h86};
    vecs[7]  = '{0, 23'd8,  32'h0FFF_FFF8, 4'hA, 1, 0, 1, 8'hFF, 8'h8A};
    vecs[8]  = '{1, 23'd16, 32'hFFFF_FFE0, 4'hB, 1, 0, 2, 8'hFF, 8'h8B};
    vecs[9]  = '{1, 23'd16, 32'hFFFF_FFF8, 4'hC, 1, 0, 0, 8'hFF, 8'h2C};
    vecs[10] = '{1, 23'd7,  32'h0000_0010, 4'hD, 1, 1, 1, 8'h7F, 8'h8D};
    vecs[11] = '{1, 23'd0,  32'h0000_0000, 4'hE, 1, 0, 0, 8'hFF, 8'h1E};
    c1       = '{0, 23'd24, 32'h0000_0500, 4'h9, 1, 0, 3, 8'hFF, 8'h89};
    c2       = '{0, 23'd12, 32'h0000_0600, 4'hA, 0, 1, 2, 8'h0F, 8'h8A};
    c6       = '{0, 23'd64, 32'h0000_0800, 4'h8, 1, 0, 8, 8'hFF, 8'h88};

    // Reset state and ready release
    #3;
    check_zero("in_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("cmd_tready_before_edge", {63'd0, rdy}, 64'd0);
    @(posedge clk);
    #1;
    check("cmd_tready_after_edge", {63'd0, rdy}, 64'd1);
    @(negedge clk);

    // Table-driven commands
    for (int i = 0; i < 12; i++) begin
      issue_cmd(vecs[i]);
      collect(vecs[i]);
    end

    // Second command held while the first is in flight
    issue_cmd(c1);
    cmd_tvalid = 1'b1;
    cmd_tdata[63:32] = c2.saddr;
    collect(c1);
    issue_cmd(c2);
    collect(c2);

    // Reset in the middle of an 8-beat transfer
    begin
      int unsigned hs = 0, n = 0, leak = 0;
      issue_cmd(c6);
      data_tready = 1'b1;
      while (hs < 3 && n < 50) begin
        if (d_tvalid) hs++;
        @(negedge clk);
        n++;
      end
      check("rst_mid_progress", 64'(hs), 64'd3);
      check("rst_mid_in_data", {63'd0, d_tvalid}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check_zero("async_rst");
      repeat (2) begin
        @(negedge clk);
        if (d_tvalid || s_tvalid) leak++;
      end
      rst = 1'b0;
      data_tready = 1'b0;
      sts_tready = 1'b1;
      #1;
      check("rdy_held_low_after_rst", {63'd0, rdy}, 64'd0);
      repeat (3) begin
        @(negedge clk);
        if (d_tvalid || s_tvalid) leak++;
      end
      sts_tready = 1'b0;
      check("abandoned_no_output", 64'(leak), 64'd0);
      check("rdy_after_rst_release", {63'd0, rdy}, 64'd1);
    end
    issue_cmd(vecs[0]);
    collect(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dm_mm2s_responder.md
DM_MM2S_RESPONDER -- requirements
Module: dm_mm2s_responder

Interface
REQ-001 Parameter: LAT_CYCLES, default 2, idle cycles between command accept and the first data beat (range 0..255).
REQ-002 Parameter: BASE_LIMIT, default 32'h1000_0000, addresses at or above this value are out of range and return DECERR.
REQ-003 Clock and reset are decided: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; all logic on the rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 s_axis_cmd_tvalid  in  1  datamover MM2S command valid.
REQ-007 s_axis_cmd_tready  out  1  command accept.
REQ-008 s_axis_cmd_tdata  in  72  command: [22:0] BTT bytes, [23] TYPE, [30] EOF, [63:32] SADDR, [67:64] TAG, others ignored.
REQ-009 m_axis_data_tvalid / tready / tdata[63:0] / tkeep[7:0] / tlast  out/in/out/out/out  MM2S read-data stream.
REQ-010 m_axis_sts_tvalid / tready / tdata[7:0] / tkeep[0:0] / tlast  out/in/out/out/out  MM2S status stream.

Function
REQ-011 The FSM SHALL have the states IDLE, WAIT, DATA and STS, with one command in flight.
REQ-012 s_axis_cmd_tready SHALL be 1 only in IDLE.
REQ-013 A command SHALL be accepted on a cycle where tvalid&&tready; on accept, BTT, SADDR, TAG and EOF are latched.
REQ-014 On accept, the FSM SHALL go to STS in these cases: BTT==0 (INTERR); SADDR>=BASE_LIMIT (DECERR); SADDR+BTT overflows 32 bits (DECERR).
REQ-015 Otherwise the FSM SHALL go to WAIT with its delay counter loaded with LAT_CYCLES.
REQ-016 WAIT SHALL last LAT_CYCLES cycles, then go to DATA; with LAT_CYCLES=0, the first beat is valid the cycle after accept.
REQ-017 DATA SHALL emit N=ceil(BTT/8) beats with beat counter k=0..N-1.
REQ-018 Beat payload: tdata = {SADDR+8k+4, SADDR+8k}, both 32-bit modulo.
REQ-019 tkeep SHALL be 8'hFF on every beat except the last; on the last beat tkeep = (1<<r)-1 where r=BTT mod 8, and r==0 gives 8'hFF.
REQ-020 tlast SHALL be 1 only on beat N-1 and only when EOF==1; with EOF==0, tlast stays 0.
REQ-021 Beat payload, tkeep, tlast and tvalid SHALL hold stable while tvalid&&!tready; k advances only on a handshake.
REQ-022 A handshake on beat N-1 SHALL move the FSM to STS on the next cycle.
REQ-023 In STS, m_axis_sts_tvalid SHALL be 1, with tkeep=1, tlast=1 and tdata = {OKAY, SLVERR, DECERR, INTERR, TAG[3:0]}.
REQ-024 Exactly one status bit among [7:4] SHALL be set; SLVERR is never set by this block.
REQ-025 The status SHALL hold until sts tready; on that handshake the FSM returns to IDLE, and cmd tready is 1 on the following cycle.
REQ-026 BTT SHALL be treated as unsigned 23-bit; the beat count register is 20 bits (max 2^20 beats).
REQ-027 A command presented while busy SHALL be back-pressured, never dropped.
REQ-028 Data and status valid SHALL never be asserted on the same cycle.
REQ-029 TYPE SHALL be ignored (INCR behaviour always).

Reset
REQ-030 While rst=1, and immediately on assertion regardless of state: FSM=IDLE; all counters=0; all tvalid=0, tlast=0, tdata=0, tkeep=0; s_axis_cmd_tready=0.
REQ-031 s_axis_cmd_tready SHALL rise on the first clk edge after rst deasserts.
REQ-032 Reset during DATA or STS SHALL abandon the command with no further beats and no status.

Verification
REQ-033 Scenario 1: cmd BTT=20, SADDR=0x100, TAG=5, EOF=1, LAT=2, tready always 1 -> 3 beats {0x104,0x100}, {0x10C,0x108}, {0x114,0x110}; tkeep FF, FF, 0F; tlast on beat 3; status 0x85.
REQ-034 Scenario 2: BTT=0, TAG=3 -> no data beats; status 0x13 on the cycle after accept.
REQ-035 Scenario 3: SADDR=0x1000_0000, BTT=8, TAG=1 -> no data; status 0x21.
REQ-036 Scenario 4: BTT=16, data tready toggled randomly -> beats stable under stall; exactly 2 handshakes; tlast=1 on the second when EOF=1, 0 when EOF=0; status 0x80|TAG.
REQ-037 Scenario 5: a second cmd asserted during DATA of the first -> cmd tready=0 until the first status handshake; the second is then accepted and completes correctly.
REQ-038 Scenario 6: rst asserted mid-DATA of an 8-beat command -> all outputs 0 asynchronously; no status; a fresh command after reset completes normally.
